id_pipe: RTL and testbench
==========================

// Module: id_pipe
// PURPOSE
// Registered, parametrised RV32I decode stage between if_id and id_ex. Decodes one
// instruction per accepted beat, reads the register file, and forwards EX/WB results.
// Stalls on load-use hazards and flushes on redirect. Upstream and downstream use
// valid/ready handshakes. Covers I, R, B, JAL, JALR, LUI, AUIPC, LOAD and STORE.
// PARAMETERS
// XLEN       32          datapath width; immediates sign-extend to XLEN
// RA_W       5           register address width
// FWD_EN     1           1: EX/WB forwarding on; 0: regfile data only, RAW hazards stall
// NOP_INST   32'h13      instruction word loaded on reset or flush (addi x0,x0,0)
// PORTS
// clk          in   1     clock
// rst          in   1     synchronous active-high reset
// in_valid     in   1     if_id presents inst_i/inst_addr_i
// in_ready     out  1     stage accepts this cycle
// inst_i       in   32    instruction word
// inst_addr_i  in   XLEN  instruction address
// flush_i      in   1     redirect: squash the output register; the input is not accepted
// rs1_addr_o   out  RA_W  regfile read address 1 (combinational from inst_i)
// rs2_addr_o   out  RA_W  regfile read address 2 (combinational from inst_i)
// rs1_data_i   in   XLEN  regfile read data 1
// rs2_data_i   in   XLEN  regfile read data 2
// ex_wen_i     in   1     EX will write ex_rd_i
// ex_rd_i      in   RA_W  EX destination register
// ex_data_i    in   XLEN  EX result; invalid when ex_load_i=1
// ex_load_i    in   1     EX instruction is a load
// wb_wen_i     in   1     WB write enable
// wb_rd_i      in   RA_W  WB destination register
// wb_data_i    in   XLEN  WB write data
// out_valid    out  1     id_ex holds a valid decode
// out_ready    in   1     id_ex consumes this cycle
// inst_o       out  32    registered instruction
// inst_addr_o  out  XLEN  registered instruction address
// op1_o        out  XLEN  operand 1
// op2_o        out  XLEN  operand 2
// st_data_o    out  XLEN  store data (forwarded rs2); 0 for non-stores
// rd_addr_o    out  RA_W  destination register
// reg_wen      out  1     writeback enable
// illegal_o    out  1     undecodable instruction
// BEHAVIOUR
// - Reset (rst=1 at clk edge): out_valid=0, inst_o=NOP_INST, and all other outputs 0.
// - Transfer: in_fire = in_valid & in_ready. On in_fire, all outputs are registered on
//   the next edge and out_valid=1. Latency is 1 cycle.
// - in_ready = (!out_valid | out_ready) & !hazard & !flush_i.
// - When out_valid=1 and out_ready=0, all outputs hold stable.
// - If out_ready=1 with no in_fire, out_valid goes to 0.
// - flush_i has top priority. Next edge: out_valid=0, inst_o=NOP_INST, reg_wen=0,
//   illegal_o=0. rst overrides flush_i.
// - Used sources: R/B/STORE use rs1 and rs2; I/JALR/LOAD use rs1 only; others use none.
//   An unused rs address is driven as 0.
// - Forwarding, per used source, in priority order:
//   1. addr==0 gives 0.
//   2. ex_wen_i & ex_rd_i==addr & !ex_load_i gives ex_data_i.
//   3. wb_wen_i & wb_rd_i==addr gives wb_data_i.
//   4. Otherwise regfile data.
// - hazard = used source addr!=0, ex_wen_i, and ex_rd_i==addr, with ex_load_i=1.
//   When FWD_EN=0, hazard is also raised on any EX or WB match.
//   While hazard=1, the instruction is not accepted and is re-evaluated every cycle.
// - Decode table (opcode/funct3 -> op1, op2, rd, reg_wen):
//   - I-ALU (ADDI/SLTI/SLTIU/XORI/ORI/ANDI): rs1, sext(I-imm), rd, 1.
//   - SLLI/SRLI/SRAI: rs1, zext(shamt), rd, 1.
//   - R (8 funct3 values): rs1, rs2, rd, 1.
//   - B (6 valid funct3 values): rs1, rs2, 0, 0.
//   - JAL: sext(J-imm), 0, rd, 1.
//   - JALR: rs1, sext(I-imm), rd, 1.
//   - LUI: {U-imm,12'b0}, 0, rd, 1.
//   - AUIPC: inst_addr_i, {U-imm,12'b0}, rd, 1.
//   - LOAD: rs1, sext(I-imm), rd, 1.
//   - STORE: rs1, sext(S-imm), 0, 0; st_data_o = rs2.
// - Illegal cases, each giving illegal_o=1 with op1/op2/rd/reg_wen=0 (still a valid beat):
//   - unknown opcode;
//   - B-type funct3 010 or 011;
//   - R-type funct7 not 0000000 or 0100000;
//   - funct7 0100000 with funct3 other than ADD_SUB or SR.
// - rd==0 keeps reg_wen=1 where listed; the regfile discards the write.
// TESTING
// 1. Reset with in_valid=1 -> out_valid=0, inst_o=32'h13, op1_o=0. First beat after
//    deassert appears 1 cycle later.
// 2. addi x1,x0,-5 (0xFFB00093) -> op1_o=0, op2_o=32'hFFFFFFFB, rd_addr_o=1, reg_wen=1.
// 3. add x3,x1,x2, EX writing x1=7, WB writing x2=9, regfile rs1/rs2=0xDEAD ->
//    op1_o=7, op2_o=9. Repeat with EX and WB both targeting x1 -> op1_o takes the EX value.
// 4. EX load to x5, then ID sub x6,x5,x4 -> in_ready=0 for exactly 1 cycle. The following
//    cycle (EX value now in WB) accepts with op1_o=wb_data_i.
// 5. out_ready=0 for 3 cycles with in_valid=1 -> outputs stable and in_ready=0. flush_i
//    pulse -> out_valid=0 and inst_o=32'h13 next edge.
// 6. Opcode 7'h7F and R-type funct7 7'h01 -> illegal_o=1, reg_wen=0, out_valid=1.

Source files
------------

// File: rtl/id_pipe_if.sv
// rtl/id_pipe_if.sv - handshake, regfile and forwarding bundle for the id_pipe decode stage
// Purpose: groups every non-clock signal of id_pipe into one bundle.
// Ports (signal groups):
//   upstream   : in_valid, in_ready, inst_i, inst_addr_i, flush_i
//   regfile    : rs1_addr_o, rs2_addr_o, rs1_data_i, rs2_data_i
//   forwarding : ex_wen_i, ex_rd_i, ex_data_i, ex_load_i, wb_wen_i, wb_rd_i, wb_data_i
//   downstream : out_valid, out_ready, inst_o, inst_addr_o, op1_o, op2_o,
//                st_data_o, rd_addr_o, reg_wen, illegal_o
// Modports: slave = decode stage side, master = surrounding pipeline side.
interface id_pipe_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] inst_addr_i;
  logic            flush_i;

  logic [RA_W-1:0] rs1_addr_o;
  logic [RA_W-1:0] rs2_addr_o;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;

  logic            ex_wen_i;
  logic [RA_W-1:0] ex_rd_i;
  logic [XLEN-1:0] ex_data_i;
  logic            ex_load_i;
  logic            wb_wen_i;
  logic [RA_W-1:0] wb_rd_i;
  logic [XLEN-1:0] wb_data_i;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_addr_o;
  logic [XLEN-1:0] op1_o;
  logic [XLEN-1:0] op2_o;
  logic [XLEN-1:0] st_data_o;
  logic [RA_W-1:0] rd_addr_o;
  logic            reg_wen;
  logic            illegal_o;

  modport slave (
    input  in_valid, inst_i, inst_addr_i, flush_i,
    input  rs1_data_i, rs2_data_i,
    input  ex_wen_i, ex_rd_i, ex_data_i, ex_load_i,
    input  wb_wen_i, wb_rd_i, wb_data_i,
    input  out_ready,
    output in_ready, rs1_addr_o, rs2_addr_o,
    output out_valid, inst_o, inst_addr_o, op1_o, op2_o,
    output st_data_o, rd_addr_o, reg_wen, illegal_o
  );

  modport master (
    output in_valid, inst_i, inst_addr_i, flush_i,
    output rs1_data_i, rs2_data_i,
    output ex_wen_i, ex_rd_i, ex_data_i, ex_load_i,
    output wb_wen_i, wb_rd_i, wb_data_i,
    output out_ready,
    input  in_ready, rs1_addr_o, rs2_addr_o,
    input  out_valid, inst_o, inst_addr_o, op1_o, op2_o,
    input  st_data_o, rd_addr_o, reg_wen, illegal_o
  );
endinterface

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - registered RV32I decode stage with regfile read, EX/WB forwarding and load-use stall
// Purpose: decodes one instruction per accepted beat into operands, destination and
//          write enable; one cycle latency, flush squashes the output register.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : id_pipe_if.slave (upstream in_* handshake, regfile read port, EX/WB
//         forwarding taps, flush_i, downstream out_* decode register)
module id_pipe #(
  parameter int          XLEN     = 32,
  parameter int          RA_W     = 5,
  parameter int          FWD_EN   = 1,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic      clk,
  input logic      rst,
  id_pipe_if.slave bus
);

  localparam bit FWD = (FWD_EN != 0);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {OP1_ZERO, OP1_RS1, OP1_IMM_J, OP1_IMM_U, OP1_PC} op1_sel_e;
  typedef enum logic [2:0] {OP2_ZERO, OP2_RS2, OP2_IMM_I, OP2_IMM_S, OP2_SHAMT, OP2_IMM_U} op2_sel_e;

  // instruction fields
  logic [6:0] w_opc;
  logic [4:0] w_rd;
  logic [2:0] w_f3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_f7;

  assign w_opc = bus.inst_i[6:0];
  assign w_rd  = bus.inst_i[11:7];
  assign w_f3  = bus.inst_i[14:12];
  assign w_rs1 = bus.inst_i[19:15];
  assign w_rs2 = bus.inst_i[24:20];
  assign w_f7  = bus.inst_i[31:25];

  // immediates: built at 32 bits, then sign-extended to XLEN
  logic [31:0]     w_imm_i32;
  logic [31:0]     w_imm_s32;
  logic [31:0]     w_imm_j32;
  logic [31:0]     w_imm_u32;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;

  assign w_imm_i32 = {{20{bus.inst_i[31]}}, bus.inst_i[31:20]};
  assign w_imm_s32 = {{20{bus.inst_i[31]}}, bus.inst_i[31:25], bus.inst_i[11:7]};
  assign w_imm_j32 = {{11{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[19:12],
                      bus.inst_i[20], bus.inst_i[30:21], 1'b0};
  assign w_imm_u32 = {bus.inst_i[31:12], 12'b0};

  assign w_imm_i = XLEN'($signed(w_imm_i32));
  assign w_imm_s = XLEN'($signed(w_imm_s32));
  assign w_imm_j = XLEN'($signed(w_imm_j32));
  assign w_imm_u = XLEN'($signed(w_imm_u32));
  assign w_shamt = XLEN'(w_rs2);

  // decode
  op1_sel_e w_op1_sel;
  op2_sel_e w_op2_sel;
  logic     w_use_rs1;
  logic     w_use_rs2;
  logic     w_wen;
  logic     w_store;
  logic     w_illegal;
  logic     w_r_legal;

  // R-type: only base (0000000) or alternate (0100000) encodings, and the
  // alternate encoding only exists for SUB and SRA
  assign w_r_legal = (w_f7 == 7'b0000000) ||
                     ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));

  always_comb begin
    w_op1_sel = OP1_ZERO;
    w_op2_sel = OP2_ZERO;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_wen     = 1'b0;
    w_store   = 1'b0;
    w_illegal = 1'b0;
    case (w_opc)
      OPC_OP_IMM: begin
        w_use_rs1 = 1'b1;
        w_wen     = 1'b1;
        w_op1_sel = OP1_RS1;
        w_op2_sel = ((w_f3 == 3'b001) || (w_f3 == 3'b101)) ? OP2_SHAMT : OP2_IMM_I;
      end
      OPC_OP: begin
        if (w_r_legal) begin
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_wen     = 1'b1;
          w_op1_sel = OP1_RS1;
          w_op2_sel = OP2_RS2;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if ((w_f3 == 3'b010) || (w_f3 == 3'b011)) begin
          w_illegal = 1'b1;
        end else begin
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_op1_sel = OP1_RS1;
          w_op2_sel = OP2_RS2;
        end
      end
      OPC_JAL: begin
        w_wen     = 1'b1;
        w_op1_sel = OP1_IMM_J;
      end
      OPC_JALR, OPC_LOAD: begin
        w_use_rs1 = 1'b1;
        w_wen     = 1'b1;
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_IMM_I;
      end
      OPC_LUI: begin
        w_wen     = 1'b1;
        w_op1_sel = OP1_IMM_U;
      end
      OPC_AUIPC: begin
        w_wen     = 1'b1;
        w_op1_sel = OP1_PC;
        w_op2_sel = OP2_IMM_U;
      end
      OPC_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_store   = 1'b1;
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_IMM_S;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // regfile read addresses; unused sources read x0 so they never match EX/WB
  logic [RA_W-1:0] w_rs1_addr;
  logic [RA_W-1:0] w_rs2_addr;

  assign w_rs1_addr     = w_use_rs1 ? RA_W'(w_rs1) : '0;
  assign w_rs2_addr     = w_use_rs2 ? RA_W'(w_rs2) : '0;
  assign bus.rs1_addr_o = w_rs1_addr;
  assign bus.rs2_addr_o = w_rs2_addr;

  // forwarding and hazard detection
  logic            w_ex_hit1;
  logic            w_ex_hit2;
  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_hazard;

  assign w_ex_hit1 = bus.ex_wen_i && (bus.ex_rd_i == w_rs1_addr) && (w_rs1_addr != '0);
  assign w_ex_hit2 = bus.ex_wen_i && (bus.ex_rd_i == w_rs2_addr) && (w_rs2_addr != '0);
  assign w_wb_hit1 = bus.wb_wen_i && (bus.wb_rd_i == w_rs1_addr) && (w_rs1_addr != '0);
  assign w_wb_hit2 = bus.wb_wen_i && (bus.wb_rd_i == w_rs2_addr) && (w_rs2_addr != '0);

  // EX beats WB because it holds the younger write to the same register
  always_comb begin
    w_rs1_val = bus.rs1_data_i;
    if (w_rs1_addr == '0) begin
      w_rs1_val = '0;
    end else if (FWD && w_ex_hit1 && !bus.ex_load_i) begin
      w_rs1_val = bus.ex_data_i;
    end else if (FWD && w_wb_hit1) begin
      w_rs1_val = bus.wb_data_i;
    end
  end

  always_comb begin
    w_rs2_val = bus.rs2_data_i;
    if (w_rs2_addr == '0) begin
      w_rs2_val = '0;
    end else if (FWD && w_ex_hit2 && !bus.ex_load_i) begin
      w_rs2_val = bus.ex_data_i;
    end else if (FWD && w_wb_hit2) begin
      w_rs2_val = bus.wb_data_i;
    end
  end

  // a load in EX has no data yet; without forwarding every in-flight match must wait
  assign w_hazard = ((w_ex_hit1 || w_ex_hit2) && bus.ex_load_i) ||
                    (!FWD && (w_ex_hit1 || w_ex_hit2 || w_wb_hit1 || w_wb_hit2));

  // operand selection
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;

  always_comb begin
    w_op1 = '0;
    case (w_op1_sel)
      OP1_RS1:   w_op1 = w_rs1_val;
      OP1_IMM_J: w_op1 = w_imm_j;
      OP1_IMM_U: w_op1 = w_imm_u;
      OP1_PC:    w_op1 = bus.inst_addr_i;
      default:   w_op1 = '0;
    endcase
  end

  always_comb begin
    w_op2 = '0;
    case (w_op2_sel)
      OP2_RS2:   w_op2 = w_rs2_val;
      OP2_IMM_I: w_op2 = w_imm_i;
      OP2_IMM_S: w_op2 = w_imm_s;
      OP2_SHAMT: w_op2 = w_shamt;
      OP2_IMM_U: w_op2 = w_imm_u;
      default:   w_op2 = '0;
    endcase
  end

  // handshake
  logic r_out_valid;
  logic w_in_ready;
  logic w_in_fire;

  assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard && !bus.flush_i;
  assign w_in_fire  = bus.in_valid && w_in_ready;

  // output register
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_inst_addr;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_st_data;
  logic [RA_W-1:0] r_rd_addr;
  logic            r_reg_wen;
  logic            r_illegal;

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      r_out_valid <= 1'b0;
      r_inst      <= NOP_INST;
      r_inst_addr <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_st_data   <= '0;
      r_rd_addr   <= '0;
      r_reg_wen   <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_inst      <= bus.inst_i;
      r_inst_addr <= bus.inst_addr_i;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_st_data   <= w_store ? w_rs2_val : '0;
      r_rd_addr   <= w_wen ? RA_W'(w_rd) : '0;
      r_reg_wen   <= w_wen;
      r_illegal   <= w_illegal;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.inst_o      = r_inst;
  assign bus.inst_addr_o = r_inst_addr;
  assign bus.op1_o       = r_op1;
  assign bus.op2_o       = r_op2;
  assign bus.st_data_o   = r_st_data;
  assign bus.rd_addr_o   = r_rd_addr;
  assign bus.reg_wen     = r_reg_wen;
  assign bus.illegal_o   = r_illegal;

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - vector table and scoreboard bench for id_pipe
module tb_id_pipe;

  logic clk = 1'b0;
  logic rst;
  logic rf_fixed;

  always #5 clk = ~clk;

  id_pipe_if #(.XLEN(32), .RA_W(5)) bus ();

  id_pipe #(
    .XLEN(32),
    .RA_W(5),
    .FWD_EN(1),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } beat_t;

  localparam int NV = 17;

  beat_t exp_q[$];
  beat_t vecs[NV];
  int    total = 0;
  int    bad   = 0;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return 32'hA000_0000 | {27'b0, a};
  endfunction

  assign bus.rs1_data_i = rf_fixed ? 32'h0000_DEAD : rf_val(bus.rs1_addr_o);
  assign bus.rs2_data_i = rf_fixed ? 32'h0000_DEAD : rf_val(bus.rs2_addr_o);

  function automatic beat_t mk(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] st, input logic [4:0] rd,
                               input logic wen, input logic ill);
    beat_t b;
    b.inst = inst; b.pc = pc; b.op1 = op1; b.op2 = op2;
    b.st = st; b.rd = rd; b.wen = wen; b.ill = ill;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // scoreboard: compare every consumed output beat against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("inst_o", bus.inst_o, e.inst);
        chk("inst_addr_o", bus.inst_addr_o, e.pc);
        chk("op1_o", bus.op1_o, e.op1);
        chk("op2_o", bus.op2_o, e.op2);
        chk("st_data_o", bus.st_data_o, e.st);
        chk("rd_addr_o", {27'b0, bus.rd_addr_o}, {27'b0, e.rd});
        chk("reg_wen", {31'b0, bus.reg_wen}, {31'b0, e.wen});
        chk("illegal_o", {31'b0, bus.illegal_o}, {31'b0, e.ill});
      end
    end
  end

  task automatic send(input beat_t e);
    int   waited;
    logic done;
    waited = 0;
    done   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.inst_i      = e.inst;
    bus.inst_addr_i = e.pc;
    while (!done && waited < 20) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic side_idle();
    bus.ex_wen_i  = 1'b0;
    bus.ex_rd_i   = '0;
    bus.ex_data_i = '0;
    bus.ex_load_i = 1'b0;
    bus.wb_wen_i  = 1'b0;
    bus.wb_rd_i   = '0;
    bus.wb_data_i = '0;
    rf_fixed      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.inst_i      = 32'hFFB0_0093;
    bus.inst_addr_i = 32'h0000_0080;
    side_idle();

    vecs[0]  = mk(32'hFFB00093, 32'h100, 32'h0,        32'hFFFFFFFB, 32'h0,        5'd1,  1'b1, 1'b0);
    vecs[1]  = mk(32'h002081B3, 32'h104, 32'hA0000001, 32'hA0000002, 32'h0,        5'd3,  1'b1, 1'b0);
    vecs[2]  = mk(32'h40428333, 32'h108, 32'hA0000005, 32'hA0000004, 32'h0,        5'd6,  1'b1, 1'b0);
    vecs[3]  = mk(32'h40345393, 32'h10C, 32'hA0000008, 32'h3,        32'h0,        5'd7,  1'b1, 1'b0);
    vecs[4]  = mk(32'h00208463, 32'h110, 32'hA0000001, 32'hA0000002, 32'h0,        5'd0,  1'b0, 1'b0);
    vecs[5]  = mk(32'h0020A463, 32'h114, 32'h0,        32'h0,        32'h0,        5'd0,  1'b0, 1'b1);
    vecs[6]  = mk(32'h010000EF, 32'h118, 32'h10,       32'h0,        32'h0,        5'd1,  1'b1, 1'b0);
    vecs[7]  = mk(32'hFFDFF06F, 32'h11C, 32'hFFFFFFFC, 32'h0,        32'h0,        5'd0,  1'b1, 1'b0);
    vecs[8]  = mk(32'hFF8280E7, 32'h120, 32'hA0000005, 32'hFFFFFFF8, 32'h0,        5'd1,  1'b1, 1'b0);
    vecs[9]  = mk(32'h12345537, 32'h124, 32'h12345000, 32'h0,        32'h0,        5'd10, 1'b1, 1'b0);
    vecs[10] = mk(32'hFFFFF597, 32'h128, 32'h128,      32'hFFFFF000, 32'h0,        5'd11, 1'b1, 1'b0);
    vecs[11] = mk(32'h00412603, 32'h12C, 32'hA0000002, 32'h4,        32'h0,        5'd12, 1'b1, 1'b0);
    vecs[12] = mk(32'hFE322A23, 32'h130, 32'hA0000004, 32'hFFFFFFF4, 32'hA0000003, 5'd0,  1'b0, 1'b0);
    vecs[13] = mk(32'h0000007F, 32'h134, 32'h0,        32'h0,        32'h0,        5'd0,  1'b0, 1'b1);
    vecs[14] = mk(32'h023100B3, 32'h138, 32'h0,        32'h0,        32'h0,        5'd0,  1'b0, 1'b1);
    vecs[15] = mk(32'h403110B3, 32'h13C, 32'h0,        32'h0,        32'h0,        5'd0,  1'b0, 1'b1);
    vecs[16] = mk(32'h7FF37293, 32'h140, 32'hA0000006, 32'h7FF,      32'h0,        5'd5,  1'b1, 1'b0);

    // reset held with a beat presented
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_inst_o", bus.inst_o, 32'h0000_0013);
    chk("reset_op1_o", bus.op1_o, 32'd0);
    chk("reset_op2_o", bus.op2_o, 32'd0);
    chk("reset_reg_wen", {31'b0, bus.reg_wen}, 32'd0);
    chk("reset_illegal_o", {31'b0, bus.illegal_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // first beat after reset, one cycle latency
    send(mk(32'hFFB00093, 32'h80, 32'h0, 32'hFFFFFFFB, 32'h0, 5'd1, 1'b1, 1'b0));
    @(negedge clk);
    chk("latency1_out_valid", {31'b0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // decode table, back to back
    for (int i = 0; i < NV; i++) begin
      send(vecs[i]);
    end
    drain();

    // forwarding: EX to rs1, WB to rs2, then both to rs1, then WB only
    rf_fixed      = 1'b1;
    bus.ex_wen_i  = 1'b1;
    bus.ex_rd_i   = 5'd1;
    bus.ex_data_i = 32'd7;
    bus.wb_wen_i  = 1'b1;
    bus.wb_rd_i   = 5'd2;
    bus.wb_data_i = 32'd9;
    send(mk(32'h002081B3, 32'h200, 32'd7, 32'd9, 32'h0, 5'd3, 1'b1, 1'b0));
    bus.wb_rd_i = 5'd1;
    send(mk(32'h002081B3, 32'h204, 32'd7, 32'h0000_DEAD, 32'h0, 5'd3, 1'b1, 1'b0));
    bus.ex_wen_i = 1'b0;
    send(mk(32'h002081B3, 32'h208, 32'd9, 32'h0000_DEAD, 32'h0, 5'd3, 1'b1, 1'b0));
    drain();
    side_idle();

    // load-use: stall exactly one cycle, then take the value from WB
    bus.ex_wen_i    = 1'b1;
    bus.ex_rd_i     = 5'd5;
    bus.ex_load_i   = 1'b1;
    bus.ex_data_i   = 32'hBAD0_BAD0;
    bus.in_valid    = 1'b1;
    bus.inst_i      = 32'h40428333;
    bus.inst_addr_i = 32'h300;
    @(negedge clk);
    chk("loaduse_stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("loaduse_rs1_addr", {27'b0, bus.rs1_addr_o}, 32'd5);
    @(posedge clk);
    #1;
    chk("loaduse_no_output", {31'b0, bus.out_valid}, 32'd0);
    bus.ex_wen_i  = 1'b0;
    bus.ex_load_i = 1'b0;
    bus.wb_wen_i  = 1'b1;
    bus.wb_rd_i   = 5'd5;
    bus.wb_data_i = 32'h1234_5678;
    @(negedge clk);
    chk("loaduse_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    if (bus.in_ready) begin
      exp_q.push_back(mk(32'h40428333, 32'h300, 32'h1234_5678, 32'hA0000004, 32'h0, 5'd6, 1'b1, 1'b0));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();
    side_idle();

    // backpressure hold for 3 cycles, then flush squashes the held beat
    bus.out_ready = 1'b0;
    send(mk(32'h12345537, 32'h400, 32'h12345000, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0));
    bus.in_valid    = 1'b1;
    bus.inst_i      = 32'hFFB00093;
    bus.inst_addr_i = 32'h404;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_inst_o", bus.inst_o, 32'h12345537);
      chk("hold_op1_o", bus.op1_o, 32'h12345000);
      chk("hold_rd_addr_o", {27'b0, bus.rd_addr_o}, 32'd10);
      chk("unused_rs2_addr", {27'b0, bus.rs2_addr_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush_i  = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_inst_o", bus.inst_o, 32'h0000_0013);
    chk("flush_reg_wen", {31'b0, bus.reg_wen}, 32'd0);
    chk("flush_illegal_o", {31'b0, bus.illegal_o}, 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // pipeline resumes after flush
    send(mk(32'h7FF37293, 32'h500, 32'hA0000006, 32'h7FF, 32'h0, 5'd5, 1'b1, 1'b0));
    drain();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
